// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wb_sequencer
// Purpose  : Register-file writeback sequencer. It forms the write value,
//            buffers pending writes in a FIFO and drains one per cycle.
//            Define WB_FWD_EN to build the decode forwarding comparators.
// Revision : 1.0  initial release
// ============================================================================
module wb_sequencer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [2:0]       in_reg,
    input  logic [WIDTH-1:0] in_alu,
    input  logic [WIDTH-1:0] in_mem,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             flush,
    input  logic             wr_stall,
    output logic             WriteEn,
    output logic [2:0]       WriteReg,
    output logic [WIDTH-1:0] WriteData,
    input  logic [2:0]       ReadReg1,
    input  logic [2:0]       ReadReg2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [WIDTH-1:0] fwd_data1,
    output logic [WIDTH-1:0] fwd_data2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    localparam logic [1:0] C_SEL_ALU  = 2'b00;
    localparam logic [1:0] C_SEL_MEM  = 2'b01;
    localparam logic [1:0] C_SEL_LINK = 2'b10;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    logic [2:0]       reg_mem_q  [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    occ_t             occ_q, occ_d;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_value;

    always_comb begin
        case (in_sel)
            C_SEL_ALU:  w_value = in_alu;
            C_SEL_MEM:  w_value = in_mem;
            C_SEL_LINK: w_value = in_pc + WIDTH'(2);
            default:    w_value = in_imm;
        endcase
    end

    assign in_ready = (occ_q != OCC_FULL);
    assign WriteEn  = (occ_q != OCC_EMPTY) & ~wr_stall;
    assign w_pop    = WriteEn;
    // An accept coinciding with flush is discarded along with the buffer.
    assign w_push   = in_valid & in_ready & ~flush;

    assign WriteReg  = (occ_q != OCC_EMPTY) ? reg_mem_q[head_q]  : 3'd0;
    assign WriteData = (occ_q != OCC_EMPTY) ? data_mem_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) tail_d = tail_q + AW'(1);
            if (w_pop)  head_d = head_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (count_d == '0)
            occ_d = OCC_EMPTY;
        else if (count_d == C_FULL)
            occ_d = OCC_FULL;
        else
            occ_d = OCC_PARTIAL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            occ_q   <= OCC_EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            occ_q   <= occ_d;
        end
    end

    // Storage is not reset: entries are only ever read below count_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            reg_mem_q[tail_q]  <= in_reg;
            data_mem_q[tail_q] <= w_value;
        end
    end

`ifdef WB_FWD_EN
    logic [AW-1:0] w_idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (reg_mem_q[w_idx] == ReadReg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem_q[w_idx];
                end
                if (reg_mem_q[w_idx] == ReadReg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem_q[w_idx];
                end
            end
        end
    end
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^{ReadReg1, ReadReg2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sequencer
// Purpose  : Directed self-checking bench for wb_sequencer (DEPTH=2, WIDTH=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_sequencer;

    localparam int WIDTH = 16;
`ifdef WB_FWD_EN
    localparam bit C_FWD = 1'b1;
`else
    localparam bit C_FWD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [2:0]       in_reg;
    logic [WIDTH-1:0] in_alu, in_mem, in_pc, in_imm;
    logic             flush;
    logic             wr_stall;
    logic             WriteEn;
    logic [2:0]       WriteReg;
    logic [WIDTH-1:0] WriteData;
    logic [2:0]       ReadReg1, ReadReg2;
    logic             fwd_hit1, fwd_hit2;
    logic [WIDTH-1:0] fwd_data1, fwd_data2;

    logic [WIDTH-1:0] rf [8];
    int               n_tests = 0;
    int               n_fail  = 0;

    wb_sequencer #(.DEPTH(2), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_reg(in_reg),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc), .in_imm(in_imm),
        .flush(flush), .wr_stall(wr_stall),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model fed by the write port.
    always @(posedge clk) begin
        if (WriteEn) rf[WriteReg] <= WriteData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] r,
                         input logic [WIDTH-1:0] val);
        in_valid = v;
        in_sel   = sel;
        in_reg   = r;
        in_alu   = val;
        in_mem   = val;
        in_pc    = val;
        in_imm   = val;
    endtask

    task automatic expect_write(input string tag, input logic en, input logic [2:0] r,
                                input logic [WIDTH-1:0] d);
        check({tag, "_en"},   WriteEn,   en);
        check({tag, "_reg"},  WriteReg,  r);
        check({tag, "_data"}, WriteData, d);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_stall = 1'b0;
        ReadReg1 = 3'd0; ReadReg2 = 3'd0;
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        step(); step();
        settle();
        check("rst_ready", in_ready, 1'b1);
        expect_write("rst_out", 1'b0, 3'd0, 16'h0000);
        check("rst_hit1", fwd_hit1, 1'b0);
        check("rst_fdata1", fwd_data1, 16'h0000);
        rst = 1'b1;
        step();

        // Each source type, one accept and one write per cycle.
        drive(1'b1, 2'b00, 3'd3, 16'h1234);
        step();
        drive(1'b1, 2'b01, 3'd4, 16'hBEEF);
        settle(); expect_write("src_alu", 1'b1, 3'd3, 16'h1234);
        step();
        drive(1'b1, 2'b10, 3'd7, 16'd10);
        settle(); expect_write("src_mem", 1'b1, 3'd4, 16'hBEEF);
        step();
        drive(1'b1, 2'b11, 3'd2, 16'h0001);
        settle(); expect_write("src_link", 1'b1, 3'd7, 16'd12);
        step();
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        settle(); expect_write("src_lbi", 1'b1, 3'd2, 16'h0001);
        step();
        settle(); expect_write("src_empty", 1'b0, 3'd0, 16'h0000);

        // Fill under stall, hold a third request, then drain.
        wr_stall = 1'b1;
        drive(1'b1, 2'b00, 3'd1, 16'h0AAA);
        step();
        drive(1'b1, 2'b10, 3'd6, 16'hFFFE);
        settle();
        check("st_ready1", in_ready, 1'b1);
        check("st_en1", WriteEn, 1'b0);
        step();
        drive(1'b1, 2'b00, 3'd5, 16'h5555);
        settle();
        check("st_full_ready", in_ready, 1'b0);
        expect_write("st_hold", 1'b0, 3'd1, 16'h0AAA);
        step();
        settle();
        check("st_still_full", in_ready, 1'b0);
        wr_stall = 1'b0;
        settle();
        check("st_ready_nodrain", in_ready, 1'b0);
        expect_write("st_drain1", 1'b1, 3'd1, 16'h0AAA);
        step();
        settle();
        check("st_ready_after_pop", in_ready, 1'b1);
        expect_write("st_link_wrap", 1'b1, 3'd6, 16'h0000);
        step();
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        settle(); expect_write("st_third", 1'b1, 3'd5, 16'h5555);
        step();
        settle(); check("st_empty", WriteEn, 1'b0);

        // Sustained accept + drain: occupancy stays at one entry.
        drive(1'b1, 2'b00, 3'd0, 16'd0);
        step();
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 2'b00, 3'(i), 16'(i));
            settle();
            expect_write($sformatf("sim_w%0d", i - 1), 1'b1, 3'(i - 1), 16'(i - 1));
            check($sformatf("sim_rdy%0d", i - 1), in_ready, 1'b1);
            step();
        end
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        settle(); expect_write("sim_w7", 1'b1, 3'd7, 16'd7);
        step();
        settle(); check("sim_empty", WriteEn, 1'b0);
        for (int i = 0; i < 8; i++)
            check($sformatf("rf_R%0d", i), rf[i], 16'(i));

        // Forwarding: youngest match wins.
        wr_stall = 1'b1;
        drive(1'b1, 2'b00, 3'd5, 16'h0011);
        step();
        drive(1'b1, 2'b00, 3'd5, 16'h0022);
        step();
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        ReadReg1 = 3'd5; ReadReg2 = 3'd6;
        settle();
        check("fwd_hit1", fwd_hit1, C_FWD);
        check("fwd_data1", fwd_data1, C_FWD ? 16'h0022 : 16'h0000);
        check("fwd_hit2", fwd_hit2, 1'b0);
        check("fwd_data2", fwd_data2, 16'h0000);

        // Flush with stall: accept dropped, nothing written.
        flush = 1'b1;
        drive(1'b1, 2'b00, 3'd3, 16'h3333);
        settle(); check("fl_en_stalled", WriteEn, 1'b0);
        step();
        flush = 1'b0; wr_stall = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        ReadReg1 = 3'd3;
        settle();
        expect_write("fl_after", 1'b0, 3'd0, 16'h0000);
        check("fl_ready", in_ready, 1'b1);
        check("fl_hit", fwd_hit1, 1'b0);
        step();
        settle(); check("fl_quiet", WriteEn, 1'b0);
        check("fl_rf5_kept", rf[5], 16'd5);

        // Flush without stall: the head write still commits.
        wr_stall = 1'b1;
        drive(1'b1, 2'b00, 3'd1, 16'h0077);
        step();
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        wr_stall = 1'b0; flush = 1'b1;
        settle(); expect_write("fl2_head", 1'b1, 3'd1, 16'h0077);
        step();
        flush = 1'b0;
        settle();
        check("fl2_en", WriteEn, 1'b0);
        check("fl2_rf1", rf[1], 16'h0077);

        // Asynchronous reset with two writes pending.
        wr_stall = 1'b1;
        drive(1'b1, 2'b00, 3'd2, 16'h0099);
        step();
        drive(1'b1, 2'b00, 3'd3, 16'h0098);
        step();
        drive(1'b0, 2'b00, 3'd0, 16'h0000);
        ReadReg1 = 3'd2;
        rst = 1'b0;
        settle();
        check("mrst_ready", in_ready, 1'b1);
        expect_write("mrst_out", 1'b0, 3'd0, 16'h0000);
        check("mrst_hit", fwd_hit1, 1'b0);
        step();
        rst = 1'b1; wr_stall = 1'b0;
        settle(); expect_write("mrst_no_stale", 1'b0, 3'd0, 16'h0000);
        step();
        settle(); check("mrst_no_stale2", WriteEn, 1'b0);
        check("mrst_rf2", rf[2], 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
